au_sub_serial: RTL
==================

Name: au_sub_serial

Overview:
Multi-cycle digit-serial binary subtractor; the inverse operation of the library's parallel-prefix adder.
- Computes d = a - b mod 2^WIDTH and an unsigned borrow flag, DIGIT bits per cycle, LSB first.
- Sits in the arithmetic unit library as the area-optimised subtract path.
- valid/ready handshake on both input and output sides.

Parameters:
WIDTH, 8, operand/result word length (>= 1)
DIGIT, 1, bits processed per cycle (1 to WIDTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
out_valid  output  1  result d/bout valid
out_ready  input  1  consumer accepts result
d  output  WIDTH  difference a - b mod 2^WIDTH
bout  output  1  borrow out, 1 iff a < b (unsigned)

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Derived constant NCYC = ceil(WIDTH/DIGIT). Operands are zero-extended internally to NCYC*DIGIT bits.
- States: IDLE, BUSY, DONE.
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, out_valid=0, d=0, bout=0, digit counter=0, operand shift regs=0.
  - in_ready=1 while in reset, since it decodes IDLE.
  - Any in-flight operation is discarded with no output.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a and ~b (zero-extended, then inverted). Set the internal carry register to 1, counter=0, go to BUSY.
- BUSY:
  - in_ready=0; in_valid is ignored.
  - Each cycle: digit slice sums a_digit + ~b_digit + carry. Store the DIGIT result bits into the result shift register, update carry, shift operands right by DIGIT, counter++.
  - After NCYC BUSY cycles, go to DONE.
- DONE:
  - out_valid=1; d holds the low WIDTH result bits; bout = ~carry_final.
  - Upper padding bits propagate the carry unchanged, so carry_final equals the carry into bit WIDTH.
  - Outputs stay stable while out_ready=0, for any number of cycles.
  - On out_valid & out_ready, go to IDLE and deassert out_valid next cycle. d/bout keep their last value (don't-care to consumer).
- Latency: input handshake at edge k gives out_valid=1 after edge k+NCYC. Throughput is one result per NCYC+2 cycles minimum (no overlap of accept and deliver).
- Simultaneous events:
  - in_valid high in DONE is not accepted; in_ready=0 until IDLE.
  - out_ready high while not out_valid has no effect.
- Arithmetic: pure unsigned modulo 2^WIDTH; signed interpretation is the consumer's concern.
- DIGIT=WIDTH degenerates to NCYC=1: one BUSY cycle.
- Parameter check at elaboration/sim start:
  - WIDTH<1, DIGIT<1 or DIGIT>WIDTH: print error with instance path, then $finish.
- Counter width: clog2(NCYC) with a minimum of 1.

Decomposition:
- Shared package au_pkg: state encoding (IDLE/BUSY/DONE) and ceil-divide / clog2 constant functions for NCYC and counter width.
- One sub-module: au_sub_digit. Combinational DIGIT-bit ripple slice with inputs x, y_inv, cin and outputs s, cout. Instantiated once in the datapath.
- Remaining FSM, counter, shift registers live in au_sub_serial.

Test Plan:
- WIDTH=8, DIGIT=3 (NCYC=3): a=0x05, b=0x03, out_ready=1 -> out_valid exactly 3 cycles after accept, d=0x02, bout=0; in_ready returns 1 the cycle after output handshake.
- Same config: a=0x03, b=0x05 -> d=0xFE, bout=1; a=0x00, b=0xFF -> d=0x01, bout=1; a=0x00, b=0x00 -> d=0x00, bout=0; a=0xFF, b=0x7F -> d=0x80, bout=0.
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles after out_valid -> d/bout/out_valid stable throughout.
  - in_valid pulsed with a=0x11, b=0x22 during BUSY/DONE -> not accepted; next result unaffected.
- Reset mid-operation: assert rst during 2nd BUSY cycle -> out_valid=0, d=0, bout=0 immediately (asynchronous); after release, in_ready=1 and a fresh a=0x10, b=0x01 gives d=0x0F, bout=0.
- WIDTH=1, DIGIT=1 and WIDTH=16, DIGIT=16: exhaustive (W=1) / 10k random (W=16) vectors vs {bout,d} = {1'b0,a} - {1'b0,b} golden model; latency 1 cycle for both.
- Illegal params (DIGIT=0, DIGIT=WIDTH+1): simulation prints error and terminates.

Source files
------------

// File: rtl/au_pkg.sv
// Shared arithmetic-unit definitions: serial FSM state encoding and the
// constant functions used to size digit counters and padded datapaths.
package au_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int ceil_div(input int n, input int dv);
        if (dv < 1) begin
            return 1;
        end
        return (n + dv - 1) / dv;
    endfunction

    // Bits needed to count n values, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/au_sub_digit.sv
// DIGIT-bit ripple slice computing x + y_inv + cin; with y_inv = ~y and
// cin = 1 on the first digit this forms x - y.
module au_sub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y_inv,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic c;

    always_comb begin
        s = '0;
        c = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = x[i] ^ y_inv[i] ^ c;
            c    = (x[i] & y_inv[i]) | (c & (x[i] ^ y_inv[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/au_sub_serial.sv
// Digit-serial unsigned subtractor: d = a - b mod 2^WIDTH plus borrow flag,
// DIGIT bits per cycle, LSB first, taking NCYC cycles per operation.
module au_sub_serial
    import au_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int NCYC = ceil_div(WIDTH, DIGIT);
    localparam int EXT  = NCYC * DIGIT;
    localparam int CW   = clog2_min1(NCYC);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH) begin : g_param_err
        $error("%m: illegal parameters WIDTH=%0d DIGIT=%0d", WIDTH, DIGIT);
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends on ready, and a DONE result is held
    // unchanged until it transfers.
    state_t          state;
    state_t          state_n;
    logic [EXT-1:0]  a_sr;
    logic [EXT-1:0]  b_sr;
    logic [EXT-1:0]  res_sr;
    logic            carry;
    logic            bout_r;
    logic [CW-1:0]   cnt;
    logic [DIGIT-1:0] s;
    logic            cout;
    logic            accept;
    logic            last;

    au_sub_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .x     (a_sr[DIGIT-1:0]),
        .y_inv (b_sr[DIGIT-1:0]),
        .cin   (carry),
        .s     (s),
        .cout  (cout)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == CW'(NCYC - 1));
    assign d         = res_sr[WIDTH-1:0];
    assign bout      = bout_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept)    state_n = ST_BUSY;
            ST_BUSY: if (last)      state_n = ST_DONE;
            ST_DONE: if (out_ready) state_n = ST_IDLE;
            default:                state_n = ST_IDLE;
        endcase
    end

    // b is padded with zeros before inversion, so the padding digits pass the
    // carry through unchanged and the final carry is the carry into bit WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            bout_r <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_sr  <= EXT'(a);
                        b_sr  <= ~EXT'(b);
                        carry <= 1'b1;
                        cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    res_sr <= (res_sr >> DIGIT) | (EXT'(s) << (EXT - DIGIT));
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    carry  <= cout;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        bout_r <= ~cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
